// File: rtl/layer_mac_sequencer.sv
// Shared signed 8x8 MAC sequenced over NUM_NODES neurons, ReLU output per node.
// Build option: define LAYER_SEQ_SAT_EN to clamp positive results to 127 instead of wrapping.
module layer_mac_sequencer #(
  parameter int NUM_INPUTS = 15,
  parameter int NUM_NODES  = 8,
  parameter int ACC_W      = 20,
  parameter int ADDR_W     = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*NUM_INPUTS-1:0]      in_data,
  output logic                         w_en,
  output logic [ADDR_W-1:0]            w_addr,
  input  logic [7:0]                   w_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic [$clog2(NUM_NODES)-1:0] out_idx,
  output logic                         out_last,
  output logic                         busy
);
  localparam int K_W   = $clog2(NUM_INPUTS + 1);
  localparam int IDX_W = $clog2(NUM_NODES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, EMIT} state_t;

  state_t                    state_q, state_d;
  logic [8*NUM_INPUTS-1:0]   vec_q, vec_d;
  logic [IDX_W-1:0]          node_q, node_d;
  logic [K_W-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      rd_vld_q, rd_vld_d;
  logic [K_W-1:0]            rd_k_q, rd_k_d;

  logic signed [7:0]         a_sel;
  logic signed [15:0]        prod;
  logic [7:0]                relu;
  logic                      last_node;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      node_q   <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_k_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      node_q   <= node_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      rd_vld_q <= rd_vld_d;
      rd_k_q   <= rd_k_d;
    end
  end

  // Activation matching the ROM word returning this cycle (issued one cycle earlier).
  always_comb begin
    a_sel = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rd_k_q == K_W'(i)) a_sel = vec_q[8*i +: 8];
    end
    prod = a_sel * $signed(w_data);
  end

  always_comb begin
    relu = '0;
    if (!acc_q[ACC_W-1]) begin
`ifdef LAYER_SEQ_SAT_EN
      relu = (acc_q > $signed(ACC_W'(127))) ? 8'd127 : acc_q[7:0];
`else
      relu = acc_q[7:0];
`endif
    end
  end

  assign last_node = (node_q == IDX_W'(NUM_NODES - 1));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    node_d   = node_q;
    k_d      = k_q;
    acc_d    = acc_q;
    in_ready = 1'b0;
    w_en     = 1'b0;
    w_addr   = '0;
    out_valid = 1'b0;
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;

    // Bias word is added unscaled; weights contribute the full 16-bit product.
    if (rd_vld_q) begin
      if (rd_k_q == K_W'(NUM_INPUTS)) acc_d = acc_q + ACC_W'($signed(w_data));
      else                            acc_d = acc_q + ACC_W'(prod);
    end

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_d   = in_data;
          node_d  = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        w_en   = 1'b1;
        w_addr = ADDR_W'(node_q) * ADDR_W'(NUM_INPUTS + 1) + ADDR_W'(k_q);
        if (k_q == K_W'(NUM_INPUTS)) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: state_d = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        out_data  = relu;
        out_idx   = node_q;
        out_last  = last_node;
        if (out_ready) begin
          if (last_node) begin
            state_d = IDLE;
          end else begin
            node_d  = node_q + 1'b1;
            k_d     = '0;
            acc_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_vld_d = w_en;
    rd_k_d   = k_q;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer with NUM_INPUTS=3, NUM_NODES=2 and a 1-cycle ROM.
module tb_layer_mac_sequencer;
  localparam int NI = 3;
  localparam int NN = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [8*NI-1:0] in_data;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [0:0]    out_idx;
  logic          out_last;
  logic          busy;

  logic [7:0] rom [8];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  layer_mac_sequencer #(.NUM_INPUTS(NI), .NUM_NODES(NN), .ACC_W(20), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_en) w_data <= rom[w_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_rom(input int node, input logic [7:0] w0, w1, w2, b);
    rom[node*4+0] = w0;
    rom[node*4+1] = w1;
    rom[node*4+2] = w2;
    rom[node*4+3] = b;
  endtask

  task automatic send_vec(input logic [7:0] a0, a1, a2, output int t);
    @(negedge clk);
    in_data  = {a2, a1, a0};
    in_valid = 1'b1;
    chk("accept_ready", int'(in_ready), 1);
    t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '1;
  endtask

  task automatic wait_out(output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
    if (!out_valid) chk("out_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic run_layer(input logic [7:0] a0, a1, a2, input int e0, e1, input string nm);
    int t0, t1, t2;
    send_vec(a0, a1, a2, t0);
    wait_out(t1);
    chk({nm, "_lat0"}, t1 - t0, 6);
    chk({nm, "_d0"}, int'(out_data), e0);
    chk({nm, "_idx0"}, int'(out_idx), 0);
    chk({nm, "_last0"}, int'(out_last), 0);
    chk({nm, "_busy"}, int'(busy), 1);
    wait_out(t2);
    chk({nm, "_gap1"}, t2 - t1, 6);
    chk({nm, "_d1"}, int'(out_data), e1);
    chk({nm, "_idx1"}, int'(out_idx), 1);
    chk({nm, "_last1"}, int'(out_last), 1);
    chk({nm, "_rdy_hold"}, int'(in_ready), 0);
    @(negedge clk);
    chk({nm, "_rdy_rise"}, int'(in_ready), 1);
    chk({nm, "_idle_vld"}, int'(out_valid), 0);
  endtask

  initial begin
    int t1, t2;
    int exp_sat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_w_en", int'(w_en), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    reset = 1'b0;

    // Basic layer plus handshake timing: node0 = 1+2+3+2, node1 = -1 -> ReLU 0.
    set_rom(0, 8'd1, 8'd1, 8'd1, 8'd2);
    set_rom(1, 8'hFF, 8'd0, 8'd0, 8'd0);
    run_layer(8'd1, 8'd2, 8'd3, 8, 0, "basic");

`ifdef LAYER_SEQ_SAT_EN
    exp_sat = 127;
`else
    exp_sat = 200;
`endif
    set_rom(0, 8'd1, 8'd1, 8'd0, 8'd0);
    set_rom(1, 8'd0, 8'd0, 8'd0, 8'd0);
    run_layer(8'd100, 8'd100, 8'd0, exp_sat, 0, "sat200");

    // 3 * (-128 * -128) + 127 = 49279; low byte is 0x7F in both builds.
    set_rom(0, 8'h80, 8'h80, 8'h80, 8'h7F);
    set_rom(1, 8'h80, 8'h80, 8'h80, 8'h7F);
    run_layer(8'h80, 8'h80, 8'h80, 127, 127, "neg128");

    // Back-pressure on node0 for 10 cycles.
    set_rom(0, 8'd1, 8'd1, 8'd1, 8'd2);
    set_rom(1, 8'hFF, 8'd0, 8'd0, 8'd0);
    out_ready = 1'b0;
    send_vec(8'd1, 8'd2, 8'd3, t1);
    wait_out(t1);
    chk("stall_d0", int'(out_data), 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_vld", int'(out_valid), 1);
      chk("stall_data", int'(out_data), 8);
      chk("stall_idx", int'(out_idx), 0);
      chk("stall_w_en", int'(w_en), 0);
    end
    out_ready = 1'b1;
    t1 = cyc;
    wait_out(t2);
    chk("stall_gap", t2 - t1, 6);
    chk("stall_d1", int'(out_data), 0);
    chk("stall_last1", int'(out_last), 1);
    @(negedge clk);
    chk("stall_idle", int'(in_ready), 1);

    // Reset while node1 is issuing aborts the layer.
    send_vec(8'd1, 8'd2, 8'd3, t1);
    wait_out(t1);
    chk("abort_d0", int'(out_data), 8);
    repeat (2) @(negedge clk);
    chk("abort_issuing", int'(w_en), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_w_en", int'(w_en), 0);
    chk("abort_w_addr", int'(w_addr), 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_out_idx", int'(out_idx), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_out", int'(out_valid), 0);
    end
    run_layer(8'd1, 8'd2, 8'd3, 8, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
